// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - scan memory walker streaming range-filtered beams to the ray tracer
module scan_sequencer #(
    parameter int                  DATA_W         = 64,
    parameter int                  ADDR_W         = 13,
    parameter int                  BEAMS_PER_SCAN = 720,
    parameter int                  NUM_SCANS      = 10,
    parameter int                  MEM_LATENCY    = 1,
    parameter logic [DATA_W/2-1:0] MIN_RANGE      = '0,
    parameter logic [DATA_W/2-1:0] MAX_RANGE      = '1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             loop_mode,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [DATA_W-1:0]                mem_data,
    output logic [DATA_W/2-1:0]              pose_x,
    output logic [DATA_W/2-1:0]              pose_y,
    output logic                             pose_update,
    output logic                             beam_valid,
    input  logic                             beam_ready,
    output logic [DATA_W/2-1:0]              beam_magnitude,
    output logic [DATA_W/2-1:0]              beam_angle,
    output logic                             scan_done,
    output logic [$clog2(NUM_SCANS+1)-1:0]   scan_index,
    output logic [15:0]                      skipped_count,
    output logic                             busy,
    output logic                             all_done
);
    localparam int HALF_W = DATA_W / 2;
    localparam int SI_W   = $clog2(NUM_SCANS + 1);
    localparam int BI_W   = $clog2(BEAMS_PER_SCAN + 1);
    localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
    localparam longint TOTAL_WORDS = longint'(NUM_SCANS) * longint'(BEAMS_PER_SCAN + 1);
    localparam logic [HALF_W-1:0] SPAN = MAX_RANGE - MIN_RANGE;

    if (TOTAL_WORDS > (64'd1 << ADDR_W)) begin : g_bad_addr_w
        $error("scan memory does not fit in ADDR_W");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
        $error("MEM_LATENCY must be 1..4");
    end
    if (MIN_RANGE > MAX_RANGE) begin : g_bad_range
        $error("MIN_RANGE exceeds MAX_RANGE");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POSE_WAIT = 3'd1,
        BEAM_WAIT = 3'd2,
        OFFER     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BI_W-1:0]    beam_idx_q, beam_idx_d;
    logic [SI_W-1:0]    scan_index_q, scan_index_d;
    logic [15:0]        skipped_q, skipped_d;
    logic [HALF_W-1:0]  pose_x_q, pose_x_d, pose_y_q, pose_y_d;
    logic [HALF_W-1:0]  mag_q, mag_d, ang_q, ang_d;
    logic               valid_q, valid_d;
    logic               pose_update_q, pose_update_d;
    logic               scan_done_q, scan_done_d;
    logic               beam_end;
    logic               data_ready;
    logic               in_range;
    logic [HALF_W:0]    rel_mag;

    // Offsetting by MIN_RANGE turns the two-sided window into one unsigned compare.
    assign rel_mag    = {1'b0, mem_data[DATA_W-1:HALF_W]} - {1'b0, MIN_RANGE};
    assign in_range   = rel_mag <= {1'b0, SPAN};
    assign data_ready = cnt_q == CNT_W'(MEM_LATENCY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            cnt_q         <= '0;
            beam_idx_q    <= '0;
            scan_index_q  <= '0;
            skipped_q     <= '0;
            pose_x_q      <= '0;
            pose_y_q      <= '0;
            mag_q         <= '0;
            ang_q         <= '0;
            valid_q       <= 1'b0;
            pose_update_q <= 1'b0;
            scan_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            cnt_q         <= cnt_d;
            beam_idx_q    <= beam_idx_d;
            scan_index_q  <= scan_index_d;
            skipped_q     <= skipped_d;
            pose_x_q      <= pose_x_d;
            pose_y_q      <= pose_y_d;
            mag_q         <= mag_d;
            ang_q         <= ang_d;
            valid_q       <= valid_d;
            pose_update_q <= pose_update_d;
            scan_done_q   <= scan_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        cnt_d         = cnt_q;
        beam_idx_d    = beam_idx_q;
        scan_index_d  = scan_index_q;
        skipped_d     = skipped_q;
        pose_x_d      = pose_x_q;
        pose_y_d      = pose_y_q;
        mag_d         = mag_q;
        ang_d         = ang_q;
        valid_d       = valid_q;
        pose_update_d = 1'b0;
        scan_done_d   = 1'b0;
        beam_end      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mem_addr_d   = '0;
                    scan_index_d = '0;
                    skipped_d    = '0;
                    beam_idx_d   = '0;
                    cnt_d        = '0;
                    state_d      = POSE_WAIT;
                end
            end
            POSE_WAIT: begin
                if (data_ready) begin
                    pose_x_d      = mem_data[DATA_W-1:HALF_W];
                    pose_y_d      = mem_data[HALF_W-1:0];
                    pose_update_d = 1'b1;
                    mem_addr_d    = mem_addr_q + 1'b1;
                    beam_idx_d    = '0;
                    cnt_d         = '0;
                    state_d       = BEAM_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BEAM_WAIT: begin
                if (data_ready) begin
                    cnt_d = '0;
                    if (in_range) begin
                        mag_d   = mem_data[DATA_W-1:HALF_W];
                        ang_d   = mem_data[HALF_W-1:0];
                        valid_d = 1'b1;
                        state_d = OFFER;
                    end else begin
                        if (skipped_q != 16'hFFFF) begin
                            skipped_d = skipped_q + 16'd1;
                        end
                        beam_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OFFER: begin
                if (beam_ready) begin
                    valid_d  = 1'b0;
                    beam_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared by accepted and filtered beams so record bookkeeping stays identical.
        if (beam_end) begin
            if (beam_idx_q != BI_W'(BEAMS_PER_SCAN - 1)) begin
                beam_idx_d = beam_idx_q + 1'b1;
                mem_addr_d = mem_addr_q + 1'b1;
                state_d    = BEAM_WAIT;
            end else begin
                scan_done_d = 1'b1;
                beam_idx_d  = '0;
                if (scan_index_q != SI_W'(NUM_SCANS - 1)) begin
                    scan_index_d = scan_index_q + 1'b1;
                    mem_addr_d   = mem_addr_q + 1'b1;
                    state_d      = POSE_WAIT;
                end else if (loop_mode) begin
                    scan_index_d = '0;
                    mem_addr_d   = '0;
                    state_d      = POSE_WAIT;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    assign mem_addr       = mem_addr_q;
    assign pose_x         = pose_x_q;
    assign pose_y         = pose_y_q;
    assign pose_update    = pose_update_q;
    assign beam_valid     = valid_q;
    assign beam_magnitude = mag_q;
    assign beam_angle     = ang_q;
    assign scan_done      = scan_done_q;
    assign scan_index     = scan_index_q;
    assign skipped_count  = skipped_q;
    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign all_done       = state_q == DONE;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer
module tb_scan_sequencer;
    localparam int DW = 16;
    localparam int AW = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    int   checks;
    int   errors;

    logic          start0, loop0, ready0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic [7:0]    px0, py0, mag0, ang0;
    logic          pu0, valid0, sd0, busy0, done0;
    logic [1:0]    si0;
    logic [15:0]   skip0;

    logic          start1, loop1, ready1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic [7:0]    px1, py1, mag1, ang1;
    logic          pu1, valid1, sd1, busy1, done1;
    logic [1:0]    si1;
    logic [15:0]   skip1;

    scan_sequencer #(.DATA_W(DW), .ADDR_W(AW), .BEAMS_PER_SCAN(4), .NUM_SCANS(2),
                     .MEM_LATENCY(1), .MIN_RANGE(8'd10), .MAX_RANGE(8'd100)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .loop_mode(loop0),
        .mem_addr(addr0), .mem_data(data0), .pose_x(px0), .pose_y(py0),
        .pose_update(pu0), .beam_valid(valid0), .beam_ready(ready0),
        .beam_magnitude(mag0), .beam_angle(ang0), .scan_done(sd0),
        .scan_index(si0), .skipped_count(skip0), .busy(busy0), .all_done(done0));

    scan_sequencer #(.DATA_W(DW), .ADDR_W(AW), .BEAMS_PER_SCAN(4), .NUM_SCANS(2),
                     .MEM_LATENCY(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .loop_mode(loop1),
        .mem_addr(addr1), .mem_data(data1), .pose_x(px1), .pose_y(py1),
        .pose_update(pu1), .beam_valid(valid1), .beam_ready(ready1),
        .beam_magnitude(mag1), .beam_angle(ang1), .scan_done(sd1),
        .scan_index(si1), .skipped_count(skip1), .busy(busy1), .all_done(done1));

    logic [DW-1:0] mem0 [0:31];
    logic [DW-1:0] mem1 [0:31];
    logic [DW-1:0] p1a, p1b;

    always @(posedge clock) data0 <= mem0[addr0];
    always @(posedge clock) begin
        p1a   <= mem1[addr1];
        p1b   <= p1a;
        data1 <= p1b;
    end

    logic [15:0] got0[$], pose0_q[$], got1[$], pose1_q[$];
    logic [AW-1:0] sd0_q[$];
    logic [1:0]  rmode;
    logic [7:0]  lfsr = 8'hA5;
    logic        hold0 = 1'b0;
    logic [15:0] hold_beam;

    always @(negedge clock) begin
        if (!reset_n) begin
            hold0 = 1'b0;
        end else if (hold0) begin
            checks++;
            assert (valid0 === 1'b1 && {mag0, ang0} === hold_beam) else begin
                errors++;
                $error("FAIL hold_stable: got valid=%0b beam=%h expected valid=1 beam=%h",
                       valid0, {mag0, ang0}, hold_beam);
            end
        end
        if (rmode == 2'd0) ready0 = 1'b1;
        else if (rmode == 2'd2) ready0 = 1'b0;
        else begin
            lfsr   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ready0 = lfsr[0];
        end
        if (reset_n) begin
            if (valid0 && ready0) got0.push_back({mag0, ang0});
            hold0     = valid0 && !ready0;
            hold_beam = {mag0, ang0};
            if (pu0) pose0_q.push_back({px0, py0});
            if (sd0) sd0_q.push_back(addr0);
            if (valid1 && ready1) got1.push_back({mag1, ang1});
            if (pu1) pose1_q.push_back({px1, py1});
        end
    end

    logic [15:0] exp_a[$]  = '{16'h1529, 16'h162A, 16'h172B, 16'h182C,
                               16'h1A2E, 16'h1B2F, 16'h1C30, 16'h1D31};
    logic [15:0] exp_b[$]  = '{16'h0A02, 16'h6403, 16'h3206, 16'h3307, 16'h3408, 16'h3509};
    logic [15:0] pose_a[$] = '{16'hA000, 16'hA505};
    logic [15:0] pose_b[$] = '{16'hB010, 16'hB515};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [15:0] got[$], input logic [15:0] expv[$]);
        chk({tag, "_count"}, got.size(), expv.size());
        for (int i = 0; i < expv.size(); i++)
            chk(tag, (i < got.size()) ? {16'h0, got[i]} : 32'hxxxxxxxx, {16'h0, expv[i]});
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic load_mem0(input bit filt);
        for (int a = 0; a < 32; a++) mem0[a] = '0;
        if (!filt) begin
            mem0[0] = 16'hA000;
            mem0[5] = 16'hA505;
            for (int a = 1; a < 10; a++)
                if (a != 5) mem0[a] = {8'(20 + a), 8'(40 + a)};
        end else begin
            mem0[0] = 16'hB010; mem0[1] = 16'h0501; mem0[2] = 16'h0A02;
            mem0[3] = 16'h6403; mem0[4] = 16'h6504; mem0[5] = 16'hB515;
            mem0[6] = 16'h3206; mem0[7] = 16'h3307; mem0[8] = 16'h3408;
            mem0[9] = 16'h3509;
        end
    endtask

    task automatic clear_q();
        got0.delete(); pose0_q.delete(); sd0_q.delete();
        got1.delete(); pose1_q.delete();
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (!done0 && n < budget) begin
            tick();
            n++;
        end
        chk("done0_timeout", done0, 1);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start0 = 0; loop0 = 0; start1 = 0; loop1 = 0; ready1 = 1'b1;
        rmode = 2'd0;
        load_mem0(1'b0);
        for (int a = 0; a < 32; a++) mem1[a] = mem0[a];
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_addr", addr0, 0);
        chk("rst_pose", {px0, py0}, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_skip", skip0, 0);

        // Basic run, sink always ready.
        clear_q();
        pulse_start0();
        chk("busy_after_start", busy0, 1);
        wait_done0(200);
        chk_seq("basic_beam", got0, exp_a);
        chk_seq("basic_pose", pose0_q, pose_a);
        chk("basic_sd_count", sd0_q.size(), 2);
        if (sd0_q.size() == 2) begin
            chk("basic_sd_addr0", sd0_q[0], 5);
            chk("basic_sd_addr1", sd0_q[1], 9);
        end
        chk("basic_busy", busy0, 0);
        chk("basic_addr_hold", addr0, 9);
        chk("basic_skip", skip0, 0);

        // Backpressured run restarted from DONE.
        rmode = 2'd1;
        clear_q();
        pulse_start0();
        wait_done0(600);
        chk_seq("bp_beam", got0, exp_a);

        // Range filter.
        rmode = 2'd0;
        load_mem0(1'b1);
        clear_q();
        pulse_start0();
        wait_done0(200);
        chk_seq("filt_beam", got0, exp_b);
        chk_seq("filt_pose", pose0_q, pose_b);
        chk("filt_skip", skip0, 2);
        chk("filt_sd_count", sd0_q.size(), 2);

        // Loop mode wrap.
        loop0 = 1'b1;
        clear_q();
        pulse_start0();
        n = 0;
        while (sd0_q.size() < 2 && n < 200) begin tick(); n++; end
        chk("loop_sd_seen", sd0_q.size(), 2);
        chk("loop_addr", addr0, 0);
        chk("loop_scan_index", si0, 0);
        chk("loop_skip_kept", skip0, 2);
        n = 0;
        while (pose0_q.size() < 3 && n < 50) begin tick(); n++; end
        chk("loop_pose_count", pose0_q.size(), 3);
        if (pose0_q.size() == 3) chk("loop_pose", pose0_q[2], 16'hB010);
        chk("loop_not_done", done0, 0);

        // Reset while a beam is parked in OFFER.
        rmode = 2'd2;
        n = 0;
        while (!valid0 && n < 50) begin tick(); n++; end
        chk("park_valid", valid0, 1);
        chk("park_beam", {mag0, ang0}, 16'h0A02);
        chk("park_skip", skip0, 3);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", valid0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_addr", addr0, 0);
        chk("arst_skip", skip0, 0);
        chk("arst_scan_index", si0, 0);
        chk("arst_pose", {px0, py0}, 0);
        tick();
        reset_n = 1'b1;
        loop0 = 1'b0;
        rmode = 2'd0;
        clear_q();
        tick();
        pulse_start0();
        wait_done0(200);
        chk_seq("rerun_beam", got0, exp_b);
        chk_seq("rerun_pose", pose0_q, pose_b);

        // MEM_LATENCY = 3 instance: exact sampling point.
        clear_q();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        n = 0;
        while (!pu1 && n < 50) begin tick(); n++; end
        chk("lat3_pose_cycles", n, 3);
        while (!valid1 && n < 50) begin tick(); n++; end
        chk("lat3_beam_cycles", n, 7);
        n = 0;
        while (!done1 && n < 300) begin tick(); n++; end
        chk("done1_timeout", done1, 1);
        chk_seq("lat3_beam", got1, exp_a);
        chk_seq("lat3_pose", pose1_q, pose_a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
